// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and defaults
package cpu_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } fetch_state_t;

    // First PC fetched after reset
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    // addi x0,x0,0 shown on instr while nothing has been fetched
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Sequential fetch stride in bytes
    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC mux (advance / redirect / hold) and misalign detect
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_advance,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc_next,
    output logic        o_misalign
);

    logic [31:0] w_target;

    // Redirect targets are word aligned by dropping the low two bits
    assign w_target = {i_redirect_pc[31:2], 2'b00};

    // Redirect beats sequential advance; otherwise the PC holds
    always_comb begin
        o_pc_next = i_pc;
        if (i_redirect) begin
            o_pc_next = w_target;
        end else if (i_advance) begin
            o_pc_next = i_pc + PC_INCR;
        end
    end

    // A redirect with non-zero low bits is reported as misaligned
    assign o_misalign = i_redirect && (i_redirect_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, imem req/ack, one-entry output register
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_imem_req;
    logic [31:0]  r_imem_addr;
    logic [31:0]  r_instr;
    logic [31:0]  r_instr_pc;
    logic         r_instr_valid;
    logic         r_misalign_err;
    logic         r_drop;

    logic [31:0]  w_pc_next;
    logic         w_misalign;
    logic         w_capture;

    // Only a return in FETCH that no redirect has made stale is kept
    assign w_capture = (r_state == FETCH) && imem_ack && !redirect && !r_drop;

    pc_next_sel u_pc_next_sel (
        .i_pc          (r_pc),
        .i_advance     (w_capture),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_pc_next     (w_pc_next),
        .o_misalign    (w_misalign)
    );

    // Fetch sequencer with registered memory-side and decode-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_pc           <= RESET_PC;
            r_imem_req     <= 1'b0;
            r_imem_addr    <= RESET_PC;
            r_instr        <= NOP_INSTR;
            r_instr_pc     <= RESET_PC;
            r_instr_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_drop         <= 1'b0;
        end else begin
            r_misalign_err <= w_misalign;
            r_pc           <= w_pc_next;
            case (r_state)
                IDLE: begin
                    r_state     <= FETCH;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= w_pc_next;
                end
                FETCH: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            // Request retired; reissue straight away at the target
                            r_imem_addr <= w_pc_next;
                        end else begin
                            // Request cannot be withdrawn: wait it out and throw it away
                            r_drop  <= 1'b1;
                            r_state <= DRAIN;
                        end
                    end else if (w_capture) begin
                        r_instr       <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= FULL;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        r_drop      <= 1'b0;
                        r_state     <= FETCH;
                        r_imem_addr <= w_pc_next;
                    end
                end
                FULL: begin
                    if (redirect || (r_instr_valid && instr_ready)) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= FETCH;
                        r_imem_req    <= 1'b1;
                        r_imem_addr   <= w_pc_next;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_imem_addr;
    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign instr_valid  = r_instr_valid;
    assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .misalign_err (misalign_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: program-order PC stream plus the live request
    logic [31:0] exp_pc;
    logic [31:0] cur_pc;
    logic [31:0] req_addr;
    bit          has_cur;
    bit          req_stale;
    int          n_instr = 0;

    // Memory responder configuration
    bit          mem_busy;
    int          mem_left;
    logic [31:0] slow_addr;
    int          slow_wait;
    int          all_wait;
    bit          rand_waits;
    bit          rogue;

    // Inputs/outputs as seen by the DUT at the upcoming edge
    logic        p_req, p_ack, p_valid, p_ready, p_redir;
    logic [31:0] p_rpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_pc    = 32'h0000_0000;
        cur_pc    = 32'h0000_0000;
        req_addr  = 32'h0000_0000;
        has_cur   = 1'b0;
        req_stale = 1'b0;
        mem_busy  = 1'b0;
        mem_left  = 0;
        p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_redir = 1'b0;
        p_rpc = 32'h0;
    endtask

    function automatic int pick_wait(input logic [31:0] a);
        if (all_wait > 0) return all_wait;
        if (a == slow_addr) return slow_wait;
        if (rand_waits) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic drive_mem();
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_left = pick_wait(imem_addr);
            end
            if (mem_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ KEY;
                mem_busy   = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_left--;
            end
        end else begin
            mem_busy   = 1'b0;
            imem_ack   = rogue && ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
        end
    endtask

    task automatic model_check();
        bit want_valid;
        chk("misalign_err", misalign_err, p_redir && (p_rpc[1:0] != 2'b00));
        if (p_redir) exp_pc = {p_rpc[31:2], 2'b00};
        if (p_req && p_ack) begin
            want_valid = !p_redir && !req_stale;
            chk("capture_valid", instr_valid, want_valid);
            req_stale = 1'b0;
        end else begin
            if (!p_valid) chk("spurious_valid", instr_valid, 1'b0);
            if (p_req) begin
                chk("req_hold", imem_req, 1'b1);
                chk("addr_hold", imem_addr, req_addr);
                if (p_redir) req_stale = 1'b1;
            end
        end
        if (imem_req && (!p_req || p_ack)) begin
            chk("new_req_addr", imem_addr, exp_pc);
            req_addr = exp_pc;
        end
        if (instr_valid && !p_valid) begin
            cur_pc  = exp_pc;
            has_cur = 1'b1;
            exp_pc  = exp_pc + 32'd4;
            n_instr++;
        end else if (p_valid) begin
            if (p_ready || p_redir) begin
                chk("consume_valid", instr_valid, 1'b0);
                chk("consume_req", imem_req, 1'b1);
            end else begin
                chk("stall_valid", instr_valid, 1'b1);
            end
        end
        if (instr_valid) chk("full_no_req", imem_req, 1'b0);
        if (has_cur) begin
            chk("instr_pc", instr_pc, cur_pc);
            chk("instr", instr, cur_pc ^ KEY);
        end
    endtask

    task automatic cycle();
        drive_mem();
        p_req = imem_req; p_ack = imem_ack; p_valid = instr_valid;
        p_ready = instr_ready; p_redir = redirect; p_rpc = redirect_pc;
        @(posedge clk);
        @(negedge clk);
        model_check();
        redirect = 1'b0;
    endtask

    task automatic run_until_instrs(input int target, input int budget, input string tag);
        int n = 0;
        while (n_instr < target && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, n_instr >= target, 1'b1);
    endtask

    initial begin
        int n;
        int start;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        slow_addr = 32'h8; slow_wait = 3; all_wait = 0; rand_waits = 1'b0; rogue = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_misalign", misalign_err, 1'b0);

        // Zero-wait streaming with 3 wait states on 0x8
        rst_n = 1'b1;
        instr_ready = 1'b1;
        run_until_instrs(4, 60, "stream_to_0xc");
        chk("stream_last_pc", instr_pc, 32'hC);

        // Downstream stall for 5 cycles, then one consume
        instr_ready = 1'b0;
        repeat (5) cycle();
        chk("stall_pc", instr_pc, 32'hC);
        chk("stall_req", imem_req, 1'b0);
        slow_addr = 32'h10; slow_wait = 2;
        instr_ready = 1'b1;
        cycle();
        chk("after_consume_addr", imem_addr, 32'h10);

        // Redirect while the 0x10 request is in wait states
        redirect = 1'b1; redirect_pc = 32'h100;
        cycle();
        n = 0;
        while (!instr_valid && n < 40) begin cycle(); n++; end
        chk("redir_valid", instr_valid, 1'b1);
        chk("redir_pc", instr_pc, 32'h100);

        // Misaligned redirect in FULL with a simultaneous consume
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
        cycle();
        chk("mis_valid", instr_valid, 1'b0);
        chk("mis_pulse", misalign_err, 1'b1);
        chk("mis_addr", imem_addr, 32'h200);
        cycle();
        chk("mis_clear", misalign_err, 1'b0);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cycle();
        start = n_instr;
        run_until_instrs(start + 3, 40, "wrap_run");
        chk("wrap_pc", instr_pc, 32'h0);

        // Randomised ready, wait states, redirects and stray acks
        rand_waits = 1'b1; rogue = 1'b1; slow_addr = 32'hFFFF_FFFF;
        start = n_instr;
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom & 32'h0000_03FF;
            end
            cycle();
        end
        chk("random_progress", n_instr > start + 20, 1'b1);

        // Reset while a stale request is draining
        rand_waits = 1'b0; rogue = 1'b0; all_wait = 6; instr_ready = 1'b1;
        n = 0;
        while (!(imem_req && !mem_busy) && n < 50) begin cycle(); n++; end
        chk("fresh_req_found", imem_req && !mem_busy, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h40;
        cycle();
        chk("drain_req", imem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", imem_req, 1'b0);
        chk("async_rst_valid", instr_valid, 1'b0);
        chk("async_rst_instr", instr, 32'h0000_0013);
        repeat (2) @(negedge clk);
        model_reset();
        all_wait = 0;
        imem_ack = 1'b0;
        rst_n = 1'b1;
        cycle();
        chk("post_rst_req", imem_req, 1'b1);
        chk("post_rst_addr", imem_addr, 32'h0);
        start = n_instr;
        run_until_instrs(start + 2, 20, "post_rst_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
